pea_top_module_1: RTL and testbench

PEA_TOP_MODULE_1 -- requirements
Module: pea_top_module_1

---
 rtl/pea_pkg.sv | 26 ++
 rtl/pea_coef_mem.sv | 51 +++++
 rtl/pea_top_module_1.sv | 277 +++++++++++++++++++++++++++
 tb/tb_pea_top_module_1.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_pkg.sv
// Shared definitions for the polynomial evaluation engine: opcodes, firing
// modes, status codes and the FSM state encodings.
package pea_pkg;

  localparam logic [7:0] OP_STP = 8'h01;
  localparam logic [7:0] OP_EVP = 8'h02;
  localparam logic [7:0] OP_RST = 8'h04;

  localparam logic [1:0] MODE_SETUP_INSTR = 2'b00;
  localparam logic [1:0] MODE_INSTR       = 2'b01;
  localparam logic [1:0] MODE_OUTPUT      = 2'b10;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_BAD_OP  = 3'd1;
  localparam logic [2:0] ST_BAD_N   = 3'd2;
  localparam logic [2:0] ST_NO_SLOT = 3'd3;
  localparam logic [2:0] ST_EMPTY   = 3'd4;

  typedef enum logic [2:0] {IDLE, GC, EXEC, OUT, DONE} state_t;

  // Sub-steps of an EXEC firing; POP phases stall while the data FIFO is empty.
  typedef enum logic [2:0] {
    PH_DECODE, PH_STP_POP, PH_STP_WR, PH_EVP_POP, PH_EVP_X, PH_EVP_STEP, PH_FIN
  } phase_t;

endpackage

// File: rtl/pea_coef_mem.sv
// Coefficient store: NUM_SLOTS x MAX_COEF words with a per-slot valid bit and
// coefficient count, one write port and one asynchronous read port.
module pea_coef_mem
  import pea_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_SLOTS = 8,
  parameter int MAX_COEF  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wrEn,
  input  logic [$clog2(NUM_SLOTS)-1:0]  i_wrSlot,
  input  logic [$clog2(MAX_COEF)-1:0]   i_wrIdx,
  input  logic [WIDTH-1:0]              i_wrData,
  input  logic                          i_setValid,
  input  logic [$clog2(MAX_COEF+1)-1:0] i_setCount,
  input  logic                          i_clrValid,
  input  logic [$clog2(NUM_SLOTS)-1:0]  i_rdSlot,
  input  logic [$clog2(MAX_COEF)-1:0]   i_rdIdx,
  output logic [WIDTH-1:0]              o_rdData,
  output logic                          o_rdValid,
  output logic [$clog2(MAX_COEF+1)-1:0] o_rdCount
);

  logic [WIDTH-1:0]              r_coef  [NUM_SLOTS][MAX_COEF];
  logic [NUM_SLOTS-1:0]          r_valid;
  logic [$clog2(MAX_COEF+1)-1:0] r_count [NUM_SLOTS];

  // Coefficient words carry no reset; the valid bit guards stale contents.
  always_ff @(posedge clk) begin
    if (i_wrEn) r_coef[i_wrSlot][i_wrIdx] <= i_wrData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) r_count[i] <= '0;
    end else if (i_clrValid) begin
      r_valid[i_wrSlot] <= 1'b0;
    end else if (i_setValid) begin
      r_valid[i_wrSlot] <= 1'b1;
      r_count[i_wrSlot] <= i_setCount;
    end
  end

  assign o_rdData  = r_coef[i_rdSlot][i_rdIdx];
  assign o_rdValid = r_valid[i_rdSlot];
  assign o_rdCount = r_count[i_rdSlot];

endmodule

// File: rtl/pea_top_module_1.sv
// Polynomial evaluation actor: fetches commands, stores coefficient slots and
// evaluates them by Horner's method. Define PEA_SAT_EN to saturate each step.
module pea_top_module_1 #(
  parameter int WIDTH       = 16,
  parameter int BUFFER_SIZE = 1024,
  parameter int NUM_SLOTS   = 8,
  parameter int MAX_COEF    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               command_in,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           invoke,
  input  logic [1:0]                     next_mode_in,
  input  logic [$clog2(BUFFER_SIZE)-1:0] data_pop,
  input  logic [$clog2(BUFFER_SIZE)-1:0] command_pop,
  output logic                           rd_in_command,
  output logic                           rd_in_data,
  output logic                           FC,
  output logic                           wr_out,
  output logic [WIDTH-1:0]               data_out_result,
  output logic [WIDTH-1:0]               data_out_status,
  output logic [7:0]                     instr,
  output logic [4:0]                     arg2
);
  import pea_pkg::*;

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int IDX_W  = $clog2(MAX_COEF);
  localparam int CNT_W  = $clog2(MAX_COEF + 1);

  state_t             r_state, w_stateNext;
  phase_t             r_phase, w_phaseNext;
  logic [1:0]         r_step, w_stepNext;
  logic               r_cmdRead, w_cmdReadNext;
  logic [7:0]         r_instr, w_instrNext;
  logic [2:0]         r_arg1, w_arg1Next;
  logic [4:0]         r_arg2, w_arg2Next;
  logic [WIDTH-1:0]   r_result, w_resultNext;
  logic [WIDTH-1:0]   r_status, w_statusNext;
  logic [WIDTH-1:0]   r_acc, w_accNext;
  logic [WIDTH-1:0]   r_x, w_xNext;
  logic [IDX_W-1:0]   r_idx, w_idxNext;

  logic               w_rdCmd, w_rdData, w_fc, w_wrOut;
  logic               w_memWr, w_memSetValid, w_memClrValid;
  logic [IDX_W-1:0]   w_memRdIdx;
  logic [WIDTH-1:0]   w_memRdData;
  logic               w_slotValid;
  logic [CNT_W-1:0]   w_slotCount;
  logic [WIDTH-1:0]   w_horner;

  pea_coef_mem #(
    .WIDTH(WIDTH), .NUM_SLOTS(NUM_SLOTS), .MAX_COEF(MAX_COEF)
  ) u_coefMem (
    .clk        (clk),
    .rst        (rst),
    .i_wrEn     (w_memWr),
    .i_wrSlot   (SLOT_W'(r_arg1)),
    .i_wrIdx    (r_idx),
    .i_wrData   (data_in),
    .i_setValid (w_memSetValid),
    .i_setCount (CNT_W'(r_arg2)),
    .i_clrValid (w_memClrValid),
    .i_rdSlot   (SLOT_W'(r_arg1)),
    .i_rdIdx    (w_memRdIdx),
    .o_rdData   (w_memRdData),
    .o_rdValid  (w_slotValid),
    .o_rdCount  (w_slotCount)
  );

`ifdef PEA_SAT_EN
  localparam int WW = 2 * WIDTH + 1;
  logic [WW-1:0] w_wide;
  assign w_wide   = WW'(r_acc) * WW'(r_x) + WW'(w_memRdData);
  assign w_horner = (w_wide > WW'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : w_wide[WIDTH-1:0];
`else
  assign w_horner = r_acc * r_x + w_memRdData;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_phase   <= PH_DECODE;
      r_step    <= '0;
      r_cmdRead <= 1'b0;
      r_instr   <= '0;
      r_arg1    <= '0;
      r_arg2    <= '0;
      r_result  <= '0;
      r_status  <= '0;
      r_acc     <= '0;
      r_x       <= '0;
      r_idx     <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_phase   <= w_phaseNext;
      r_step    <= w_stepNext;
      r_cmdRead <= w_cmdReadNext;
      r_instr   <= w_instrNext;
      r_arg1    <= w_arg1Next;
      r_arg2    <= w_arg2Next;
      r_result  <= w_resultNext;
      r_status  <= w_statusNext;
      r_acc     <= w_accNext;
      r_x       <= w_xNext;
      r_idx     <= w_idxNext;
    end
  end

  // Pulses are decoded from the state so reset drops every output at once.
  always_comb begin
    w_stateNext   = r_state;
    w_phaseNext   = r_phase;
    w_stepNext    = r_step;
    w_cmdReadNext = r_cmdRead;
    w_instrNext   = r_instr;
    w_arg1Next    = r_arg1;
    w_arg2Next    = r_arg2;
    w_resultNext  = r_result;
    w_statusNext  = r_status;
    w_accNext     = r_acc;
    w_xNext       = r_x;
    w_idxNext     = r_idx;
    w_rdCmd       = 1'b0;
    w_rdData      = 1'b0;
    w_fc          = 1'b0;
    w_wrOut       = 1'b0;
    w_memWr       = 1'b0;
    w_memSetValid = 1'b0;
    w_memClrValid = 1'b0;
    w_memRdIdx    = r_idx - 1'b1;

    case (r_state)
      IDLE: begin
        if (invoke) begin
          w_stepNext  = 2'd0;
          w_phaseNext = PH_DECODE;
          case (next_mode_in)
            MODE_SETUP_INSTR: w_stateNext = GC;
            MODE_INSTR:       w_stateNext = EXEC;
            MODE_OUTPUT:      w_stateNext = OUT;
            default:          w_stateNext = DONE;
          endcase
        end
      end

      GC: begin
        case (r_step)
          2'd0: begin
            w_cmdReadNext = (command_pop != '0);
            w_rdCmd       = w_cmdReadNext;
            w_stepNext    = 2'd1;
          end
          2'd1: begin
            if (r_cmdRead) begin
              w_instrNext = command_in[15:8];
              w_arg1Next  = command_in[7:5];
              w_arg2Next  = command_in[4:0];
            end else begin
              w_statusNext = WIDTH'(ST_EMPTY);
            end
            w_stepNext = 2'd2;
          end
          default: begin
            w_fc        = 1'b1;
            w_stateNext = IDLE;
          end
        endcase
      end

      EXEC: begin
        case (r_phase)
          PH_DECODE: begin
            case (r_instr)
              OP_STP: begin
                if (r_arg2 == '0 || 32'(r_arg2) > MAX_COEF) begin
                  w_statusNext = WIDTH'(ST_BAD_N);
                  w_phaseNext  = PH_FIN;
                end else begin
                  w_idxNext   = '0;
                  w_phaseNext = PH_STP_POP;
                end
              end
              OP_EVP: w_phaseNext = PH_EVP_POP;
              OP_RST: begin
                w_memClrValid = 1'b1;
                w_resultNext  = '0;
                w_statusNext  = WIDTH'(ST_OK);
                w_phaseNext   = PH_FIN;
              end
              default: begin
                w_statusNext = WIDTH'(ST_BAD_OP);
                w_phaseNext  = PH_FIN;
              end
            endcase
          end
          PH_STP_POP: begin
            if (data_pop != '0) begin
              w_rdData    = 1'b1;
              w_phaseNext = PH_STP_WR;
            end
          end
          PH_STP_WR: begin
            w_memWr = 1'b1;
            if (r_idx == IDX_W'(r_arg2 - 5'd1)) begin
              w_memSetValid = 1'b1;
              w_statusNext  = WIDTH'(ST_OK);
              w_phaseNext   = PH_FIN;
            end else begin
              w_idxNext   = r_idx + 1'b1;
              w_phaseNext = PH_STP_POP;
            end
          end
          PH_EVP_POP: begin
            if (data_pop != '0) begin
              w_rdData    = 1'b1;
              w_phaseNext = PH_EVP_X;
            end
          end
          PH_EVP_X: begin
            w_xNext = data_in;
            if (!w_slotValid) begin
              w_resultNext = '0;
              w_statusNext = WIDTH'(ST_NO_SLOT);
              w_phaseNext  = PH_FIN;
            end else begin
              w_memRdIdx  = IDX_W'(w_slotCount - 1'b1);
              w_accNext   = w_memRdData;
              w_idxNext   = IDX_W'(w_slotCount - 1'b1);
              w_phaseNext = PH_EVP_STEP;
            end
          end
          PH_EVP_STEP: begin
            if (r_idx == '0) begin
              w_resultNext = r_acc;
              w_statusNext = WIDTH'(ST_OK);
              w_phaseNext  = PH_FIN;
            end else begin
              w_accNext = w_horner;
              w_idxNext = r_idx - 1'b1;
            end
          end
          default: begin
            w_fc        = 1'b1;
            w_stateNext = IDLE;
          end
        endcase
      end

      OUT: begin
        if (r_step == 2'd0) begin
          w_wrOut    = 1'b1;
          w_stepNext = 2'd1;
        end else begin
          w_fc        = 1'b1;
          w_stateNext = IDLE;
        end
      end

      default: begin
        w_fc        = 1'b1;
        w_stateNext = IDLE;
      end
    endcase
  end

  assign rd_in_command   = w_rdCmd;
  assign rd_in_data      = w_rdData;
  assign FC              = w_fc;
  assign wr_out          = w_wrOut;
  assign data_out_result = r_result;
  assign data_out_status = r_status;
  assign instr           = r_instr;
  assign arg2            = r_arg2;

endmodule

// File: tb/tb_pea_top_module_1.sv
// Directed bench for pea_top_module_1: models both input FIFOs and checks
// firing timing, Horner results, status codes and reset behaviour.
module tb_pea_top_module_1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] command_in = '0, data_in = '0;
  logic        invoke = 1'b0;
  logic [1:0]  next_mode_in = '0;
  logic [9:0]  data_pop = '0, command_pop = '0;
  logic        rd_in_command, rd_in_data, FC, wr_out;
  logic [15:0] data_out_result, data_out_status;
  logic [7:0]  instr;
  logic [4:0]  arg2;

  int checks = 0;
  int errors = 0;

  logic [15:0] cmdQ[$];
  logic [15:0] dataQ[$];
  logic        oCmd, oData, oFc, oWr;
  logic [15:0] resAtWr, statAtWr;
  int          nCmd, nData, nWr, cmdAt, wrAt, fcAt, overlap;

  pea_top_module_1 dut (
    .clk(clk), .rst(rst), .command_in(command_in), .data_in(data_in),
    .invoke(invoke), .next_mode_in(next_mode_in), .data_pop(data_pop),
    .command_pop(command_pop), .rd_in_command(rd_in_command),
    .rd_in_data(rd_in_data), .FC(FC), .wr_out(wr_out),
    .data_out_result(data_out_result), .data_out_status(data_out_status),
    .instr(instr), .arg2(arg2)
  );

  always #5 clk = ~clk;

  // One clock: observe at negedge, present FIFO heads, update counts after the edge.
  task automatic cycle();
    @(negedge clk);
    oCmd = rd_in_command; oData = rd_in_data; oFc = FC; oWr = wr_out;
    if (oWr) begin resAtWr = data_out_result; statAtWr = data_out_status; end
    if (oCmd && cmdQ.size() > 0) command_in = cmdQ.pop_front();
    if (oData && dataQ.size() > 0) data_in = dataQ.pop_front();
    @(posedge clk);
    #1;
    if (oCmd && command_pop != 0) command_pop = command_pop - 10'd1;
    if (oData && data_pop != 0) data_pop = data_pop - 10'd1;
  endtask

  task automatic pushCmd(input logic [15:0] w);
    cmdQ.push_back(w);
    command_pop = command_pop + 10'd1;
  endtask

  task automatic pushData(input logic [15:0] w);
    dataQ.push_back(w);
    data_pop = data_pop + 10'd1;
  endtask

  task automatic observe(input int budget);
    nCmd = 0; nData = 0; nWr = 0; cmdAt = 0; wrAt = 0; fcAt = 0; overlap = 0;
    for (int c = 1; c <= budget; c++) begin
      cycle();
      if (int'(oCmd) + int'(oData) + int'(oFc) + int'(oWr) > 1) overlap++;
      if (oCmd) begin nCmd++; cmdAt = c; end
      if (oData) nData++;
      if (oWr) begin nWr++; wrAt = c; end
      if (oFc) begin fcAt = c; break; end
    end
  endtask

  task automatic fire(input logic [1:0] mode, input int budget);
    invoke = 1'b1;
    next_mode_in = mode;
    cycle();
    invoke = 1'b0;
    observe(budget);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({rd_in_command, rd_in_data, FC, wr_out, data_out_result, data_out_status, instr, arg2} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h required 0", {data_out_result, data_out_status, instr, arg2});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_gc_single();
    pushCmd(16'h0105);
    fire(2'b00, 8);
    checks++; if (nCmd !== 1) begin errors++; $display("[TB] FAIL gc_rd_count: got %0d required 1", nCmd); end
    checks++; if (cmdAt !== 1) begin errors++; $display("[TB] FAIL gc_rd_cycle: got %0d required 1", cmdAt); end
    checks++; if (fcAt !== 3) begin errors++; $display("[TB] FAIL gc_fc_cycle: got %0d required 3", fcAt); end
    checks++; if (instr !== 8'h01) begin errors++; $display("[TB] FAIL gc_instr: got %h required 01", instr); end
    checks++; if (arg2 !== 5'd5) begin errors++; $display("[TB] FAIL gc_arg2: got %0d required 5", arg2); end
  endtask

  task automatic test_gc_sequence();
    logic [15:0] cmds [6] = '{16'h0203, 16'h04E1, 16'h0110, 16'hFF1F, 16'h0A00, 16'h02A7};
    logic [7:0]  expI [6] = '{8'h02, 8'h04, 8'h01, 8'hFF, 8'h0A, 8'h02};
    logic [4:0]  expA [6] = '{5'd3, 5'd1, 5'd16, 5'd31, 5'd0, 5'd7};
    for (int i = 0; i < 6; i++) pushCmd(cmds[i]);
    for (int i = 0; i < 6; i++) begin
      fire(2'b00, 8);
      checks++; if (fcAt !== 3) begin errors++; $display("[TB] FAIL seq_fc[%0d]: got %0d required 3", i, fcAt); end
      checks++; if (instr !== expI[i]) begin errors++; $display("[TB] FAIL seq_instr[%0d]: got %h required %h", i, instr, expI[i]); end
      checks++; if (arg2 !== expA[i]) begin errors++; $display("[TB] FAIL seq_arg2[%0d]: got %0d required %0d", i, arg2, expA[i]); end
    end
    checks++; if (command_pop !== 10'd0) begin errors++; $display("[TB] FAIL seq_pop_end: got %0d required 0", command_pop); end
  endtask

  task automatic test_stp_evp();
    pushCmd(16'h0103); pushCmd(16'h0203);
    pushData(16'd1); pushData(16'd2); pushData(16'd3); pushData(16'd2);
    fire(2'b00, 8);
    fire(2'b01, 20);
    checks++; if (nData !== 3) begin errors++; $display("[TB] FAIL stp_pops: got %0d required 3", nData); end
    checks++; if (overlap !== 0) begin errors++; $display("[TB] FAIL stp_overlap: got %0d required 0", overlap); end
    fire(2'b00, 8);
    fire(2'b01, 20);
    checks++; if (nData !== 1) begin errors++; $display("[TB] FAIL evp_pops: got %0d required 1", nData); end
    fire(2'b10, 6);
    checks++; if (nWr !== 1 || wrAt !== 1) begin errors++; $display("[TB] FAIL out_wr: got %0d@%0d required 1@1", nWr, wrAt); end
    checks++; if (fcAt !== 2) begin errors++; $display("[TB] FAIL out_fc: got %0d required 2", fcAt); end
    checks++; if (resAtWr !== 16'd17) begin errors++; $display("[TB] FAIL evp_result: got %0d required 17", resAtWr); end
    checks++; if (statAtWr !== 16'd0) begin errors++; $display("[TB] FAIL evp_status: got %0d required 0", statAtWr); end
  endtask

  task automatic test_stall();
    pushCmd(16'h0122);
    pushData(16'd5);
    fire(2'b00, 8);
    fire(2'b01, 10);
    checks++; if (fcAt !== 0 || nData !== 1) begin errors++; $display("[TB] FAIL stall_hold: got fc@%0d pops %0d required fc@0 pops 1", fcAt, nData); end
    pushData(16'd7);
    observe(10);
    checks++; if (fcAt !== 3 || nData !== 1) begin errors++; $display("[TB] FAIL stall_resume: got fc@%0d pops %0d required fc@3 pops 1", fcAt, nData); end
    pushCmd(16'h0222);
    pushData(16'd3);
    fire(2'b00, 8); fire(2'b01, 20); fire(2'b10, 6);
    checks++; if (resAtWr !== 16'd26) begin errors++; $display("[TB] FAIL stall_result: got %0d required 26", resAtWr); end
  endtask

  task automatic test_saturation();
    logic [15:0] expR;
`ifdef PEA_SAT_EN
    expR = 16'hFFFF;
`else
    expR = 16'hFFFE;
`endif
    pushCmd(16'h0142); pushCmd(16'h0242);
    pushData(16'h0000); pushData(16'hFFFF); pushData(16'h0002);
    fire(2'b00, 8); fire(2'b01, 20);
    fire(2'b00, 8); fire(2'b01, 20);
    fire(2'b10, 6);
    checks++; if (resAtWr !== expR) begin errors++; $display("[TB] FAIL horner_wrap_sat: got %h required %h", resAtWr, expR); end
  endtask

  task automatic test_rst_opcode();
    pushCmd(16'h0400); pushCmd(16'h0203);
    pushData(16'd9);
    fire(2'b00, 8); fire(2'b01, 10);
    checks++; if (nData !== 0) begin errors++; $display("[TB] FAIL rst_pops: got %0d required 0", nData); end
    fire(2'b10, 6);
    checks++; if (resAtWr !== 16'd0 || statAtWr !== 16'd0) begin errors++; $display("[TB] FAIL rst_out: got %h/%h required 0000/0000", resAtWr, statAtWr); end
    fire(2'b00, 8); fire(2'b01, 20);
    checks++; if (nData !== 1) begin errors++; $display("[TB] FAIL noslot_pops: got %0d required 1", nData); end
    fire(2'b10, 6);
    checks++; if (resAtWr !== 16'd0 || statAtWr !== 16'd3) begin errors++; $display("[TB] FAIL noslot_out: got %h/%h required 0000/0003", resAtWr, statAtWr); end
  endtask

  task automatic test_bad_commands();
    pushCmd(16'h0160);
    fire(2'b00, 8); fire(2'b01, 10);
    checks++; if (nData !== 0) begin errors++; $display("[TB] FAIL badn_pops: got %0d required 0", nData); end
    fire(2'b10, 6);
    checks++; if (statAtWr !== 16'd2) begin errors++; $display("[TB] FAIL badn_status: got %0d required 2", statAtWr); end
    pushCmd(16'hFF00);
    pushData(16'd4);
    fire(2'b00, 8); fire(2'b01, 10);
    checks++; if (nData !== 0 || fcAt == 0) begin errors++; $display("[TB] FAIL badop_pops: got %0d fc@%0d required 0 with fc", nData, fcAt); end
    fire(2'b10, 6);
    checks++; if (statAtWr !== 16'd1) begin errors++; $display("[TB] FAIL badop_status: got %0d required 1", statAtWr); end
    void'(dataQ.pop_front());
    data_pop = '0;
  endtask

  task automatic test_gc_empty();
    fire(2'b00, 8);
    checks++; if (nCmd !== 0 || fcAt !== 3) begin errors++; $display("[TB] FAIL empty_gc: got rd %0d fc@%0d required rd 0 fc@3", nCmd, fcAt); end
    checks++; if (instr !== 8'hFF) begin errors++; $display("[TB] FAIL empty_instr: got %h required ff", instr); end
    fire(2'b10, 6);
    checks++; if (statAtWr !== 16'd4) begin errors++; $display("[TB] FAIL empty_status: got %0d required 4", statAtWr); end
  endtask

  task automatic test_done();
    fire(2'b11, 6);
    checks++; if (fcAt !== 1 || nCmd + nData + nWr !== 0) begin errors++; $display("[TB] FAIL done_mode: got fc@%0d others %0d required fc@1 others 0", fcAt, nCmd + nData + nWr); end
  endtask

  task automatic test_reset_mid();
    int fcSeen;
    pushCmd(16'h01A2);
    fire(2'b00, 8);
    fire(2'b01, 4);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({rd_in_command, rd_in_data, FC, wr_out, data_out_result, data_out_status, instr, arg2} !== '0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %h required 0", {data_out_status, instr, arg2});
    end
    fcSeen = 0;
    for (int i = 0; i < 3; i++) begin cycle(); if (oFc) fcSeen++; end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin cycle(); if (oFc) fcSeen++; end
    checks++; if (fcSeen !== 0) begin errors++; $display("[TB] FAIL midreset_fc: got %0d required 0", fcSeen); end
    fire(2'b10, 6);
    checks++; if (fcAt !== 2 || statAtWr !== 16'd0) begin errors++; $display("[TB] FAIL midreset_out: got fc@%0d status %0d required fc@2 status 0", fcAt, statAtWr); end
  endtask

  initial begin
    test_reset();
    test_gc_single();
    test_gc_sequence();
    test_stp_evp();
    test_stall();
    test_saturation();
    test_rst_opcode();
    test_bad_commands();
    test_gc_empty();
    test_done();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
